round_judge: RTL and testbench

- Game-engine stage directly upstream of the progress-bar updater.
- Each round, it generates an 8-bit target pattern with an LFSR, shows it, and waits for the player to submit an answer on the switches within a time limit.
- Produces single-cycle pass and fail pulses; the pass pulse drives the progress bar's pass input.
- Consumes the progress bar's game-finished flag to stop issuing rounds.

---
 rtl/round_judge.sv | 134 +++++++++++++
 tb/tb_round_judge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/round_judge.sv
// round_judge: per-round LFSR target generator and answer/timeout judge for the progress-bar game.
// Latency: LOAD takes 1 cycle; pulses, target and status outputs are registered (1 cycle after the sampled condition).
// Backpressure: none; start is honoured only in IDLE, submit only in WAIT. Define ROUND_JUDGE_LIVES_EN to enable lives tracking.
module round_judge #(
    parameter int          TIMEOUT = 100_000_000,
    parameter int          GAP     = 50_000_000,
    parameter logic [7:0]  SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       submit,
    input  logic [7:0] answer,
    input  logic       game_finished,
    output logic [7:0] target,
    output logic       is_passed,
    output logic       is_failed,
    output logic       round_active,
    output logic [1:0] lives,
    output logic       game_over
);

    // One counter serves both the WAIT time limit and the SHOW gap, so it is sized for the larger.
    localparam int             CMAX       = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int             TW         = $clog2(CMAX + 1);
    localparam logic [TW-1:0]  TIMER_LOAD = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]  GAP_LOAD   = TW'(GAP - 1);
    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [7:0]     SEED_EFF   = (SEED == 8'h00) ? 8'h01 : SEED;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_SHOW = 3'd3;
    localparam logic [2:0] S_OVER = 3'd4;

    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [7:0]    lfsr;
    logic [TW-1:0] timer;
    logic          out_of_lives;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

`ifdef ROUND_JUDGE_LIVES_EN
    logic wrong;

    // A round is lost on a wrong answer, or on expiry when no answer arrives that cycle.
    always_comb begin
        wrong = 1'b0;
        if (state == S_WAIT) begin
            wrong = submit ? (answer != target) : (timer == '0);
        end
    end

    // Lives count down on each lost round and stick at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lives <= 2'd3;
        end else if (wrong && lives != 2'd0) begin
            lives <= lives - 2'd1;
        end
    end

    assign out_of_lives = (lives == 2'd0);
`else
    assign lives        = 2'd3;
    assign out_of_lives = 1'b0;
`endif

    // Next-state selection; in WAIT a submit always takes precedence over the timeout.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = S_LOAD;
            S_LOAD: next_state = S_WAIT;
            S_WAIT: if (submit || timer == '0) next_state = S_SHOW;
            S_SHOW: begin
                if (timer == '0) begin
                    if (game_finished || out_of_lives) next_state = S_OVER;
                    else                               next_state = S_LOAD;
                end
            end
            S_OVER: next_state = S_OVER;
            default: next_state = S_IDLE;
        endcase
    end

    // State, LFSR, target, timer and registered pulse/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            lfsr         <= SEED_EFF;
            target       <= 8'h00;
            timer        <= '0;
            is_passed    <= 1'b0;
            is_failed    <= 1'b0;
            round_active <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= next_state;
            is_passed    <= 1'b0;
            is_failed    <= 1'b0;
            round_active <= (next_state == S_WAIT);
            game_over    <= (next_state == S_OVER);
            case (state)
                S_LOAD: begin
                    lfsr   <= lfsr_step(lfsr);
                    target <= lfsr_step(lfsr);
                    timer  <= TIMER_LOAD;
                end
                S_WAIT: begin
                    if (submit) begin
                        if (answer == target) is_passed <= 1'b1;
                        else                  is_failed <= 1'b1;
                        timer <= GAP_LOAD;
                    end else if (timer == '0) begin
                        is_failed <= 1'b1;
                        timer     <= GAP_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_SHOW: begin
                    if (timer != '0) timer <= timer - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_round_judge.sv
// Bench for round_judge: directed rounds with a scoreboard of expected pulses and lives.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: not applicable; every wait on the DUT is bounded.
module tb_round_judge;

    localparam int         TO = 20;
    localparam int         GP = 4;
    localparam logic [7:0] SD = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       submit = 1'b0;
    logic [7:0] answer = 8'h00;
    logic       game_finished = 1'b0;
    logic [7:0] target;
    logic       is_passed;
    logic       is_failed;
    logic       round_active;
    logic [1:0] lives;
    logic       game_over;

    round_judge #(.TIMEOUT(TO), .GAP(GP), .SEED(SD)) dut (
        .clk(clk), .reset(reset), .start(start), .submit(submit), .answer(answer),
        .game_finished(game_finished), .target(target), .is_passed(is_passed),
        .is_failed(is_failed), .round_active(round_active), .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       p;
        logic       f;
        logic [1:0] l;
    } ev_t;

    ev_t        sb[$];
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] m_lfsr;
    logic [1:0] m_lives;

    function automatic logic [7:0] stepf(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic start_game;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits for round_active and advances the target model by one LFSR step.
    task automatic wait_active(input string tag, output int n);
        n = 0;
        while (!round_active && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_active"}, round_active, 1'b1);
        m_lfsr = stepf(m_lfsr);
        chk({tag, "_target"}, target, m_lfsr);
    endtask

    task automatic push_ev(input logic pass);
        ev_t e;
        if (!pass) begin
`ifdef ROUND_JUDGE_LIVES_EN
            if (m_lives != 2'd0) m_lives = m_lives - 2'd1;
`endif
        end
        e.p = pass;
        e.f = !pass;
        e.l = m_lives;
        sb.push_back(e);
    endtask

    // Waits for the next pulse, compares it with the scoreboard head, then checks it lasts one cycle.
    task automatic observe(input string tag, input int bound, output int n);
        ev_t e;
        n = 0;
        while (!(is_passed || is_failed) && n < bound) begin
            tick();
            n++;
        end
        chk({tag, "_pulse_seen"}, is_passed | is_failed, 1'b1);
        if (sb.size() == 0) begin
            e = '0;
            chk({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            e = sb.pop_front();
        end
        chk({tag, "_passed"}, is_passed, e.p);
        chk({tag, "_failed"}, is_failed, e.f);
        chk({tag, "_lives"}, lives, e.l);
        tick();
        chk({tag, "_one_cycle"}, {is_passed, is_failed}, 2'b00);
        chk({tag, "_inactive"}, round_active, 1'b0);
    endtask

    task automatic play(input string tag, input logic [7:0] ans, input logic pass);
        int n;
        push_ev(pass);
        submit = 1'b1;
        answer = ans;
        tick();
        submit = 1'b0;
        observe(tag, 0, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        m_lfsr  = SD;
        m_lives = 2'd3;
        repeat (2) tick();
        chk("rst_target", target, 8'h00);
        chk("rst_lives", lives, 2'd3);
        chk("rst_flags", {is_passed, is_failed, round_active, game_over}, 4'b0000);
        reset = 1'b0;
        tick();

        // Round 1: first target appears on the 2nd edge after start.
        start_game();
        chk("r1_load_inactive", round_active, 1'b0);
        wait_active("r1", n);
        chk("r1_latency", n, 1);
        chk("r1_target_lit", target, 8'h4A);
        chk("r1_lives", lives, 2'd3);
        play("r1", 8'h4A, 1'b1);
        wait_active("r2", n);
        chk("show_gap", n, GP);
        chk("r2_target_lit", target, 8'h95);

        // Round 2 wrong answer, round 3 timeout.
        play("r2", 8'h00, 1'b0);
        wait_active("r3", n);
        push_ev(1'b0);
        observe("r3_timeout", 40, n);
        chk("timeout_len", n, TO);

        // Round 4: correct submit on the cycle the timer expires.
        wait_active("r4", n);
        repeat (TO - 1) tick();
        chk("r4_still_waiting", {round_active, is_failed}, 2'b10);
        play("r4_edge", m_lfsr, 1'b1);

        // Round 5: wrong answer; with lives enabled this is the last life.
        wait_active("r5", n);
        play("r5", ~m_lfsr, 1'b0);
`ifdef ROUND_JUDGE_LIVES_EN
        n = 0;
        while (!game_over && n < 20) begin
            tick();
            n++;
        end
        chk("over_flag", game_over, 1'b1);
        chk("over_lives", lives, 2'd0);
        start_game();
        submit = 1'b1;
        answer = m_lfsr;
        tick();
        submit = 1'b0;
        bad = 0;
        repeat (30) begin
            tick();
            if (is_passed || is_failed || round_active || !game_over) bad++;
        end
        chk("over_sticky_quiet", bad, 0);
        chk("over_target_held", target, m_lfsr);
`else
        wait_active("r6", n);
        chk("nolives_no_over", game_over, 1'b0);
        chk("nolives_lives", lives, 2'd3);
`endif

        // game_finished during SHOW after a pass ends the game.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_lfsr  = SD;
        m_lives = 2'd3;
        tick();
        start_game();
        wait_active("gf", n);
        game_finished = 1'b1;
        play("gf", m_lfsr, 1'b1);
        n = 0;
        while (!game_over && n < 20) begin
            tick();
            n++;
        end
        chk("gf_over", game_over, 1'b1);
        bad = 0;
        repeat (20) begin
            tick();
            if (round_active || is_passed || is_failed) bad++;
        end
        chk("gf_no_load", bad, 0);
        chk("gf_target_held", target, m_lfsr);
        game_finished = 1'b0;

        // Reset mid-WAIT discards the round without a pulse.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_lfsr = SD;
        tick();
        start_game();
        wait_active("mr", n);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        chk("mr_target", target, 8'h00);
        chk("mr_lives", lives, 2'd3);
        chk("mr_flags", {is_passed, is_failed, round_active, game_over}, 4'b0000);
        tick();
        reset = 1'b0;
        bad = 0;
        repeat (30) begin
            tick();
            if (is_passed || is_failed || round_active || target != 8'h00) bad++;
        end
        chk("mr_idle_quiet", bad, 0);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
